// File: rtl/spif_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spif_pkt_pkg
// Description : Shared SpiNNaker packet layout: header bit positions, key and
//               payload slices, multicast type code and a parity helper.
//               Used by both the packet assembler and disassembler.
// Revision    : 1.0 - initial release
// ============================================================================
package spif_pkt_pkg;

    localparam int PKT_BITS_DEFAULT = 72;

    // Header bit positions
    localparam int PTY_BIT = 0;
    localparam int PLD_BIT = 1;
    localparam int TYP_MSB = 7;
    localparam int TYP_LSB = 6;

    // Field slice bounds within the packet
    localparam int HDR_MSB = 7;
    localparam int HDR_LSB = 0;
    localparam int KEY_MSB = 39;
    localparam int KEY_LSB = 8;
    localparam int PLD_MSB = 71;
    localparam int PLD_LSB = 40;

    localparam logic [1:0] PKT_TYPE_MC = 2'b00;

    // Odd parity over header and key, plus payload only when it is present
    function automatic logic pkt_parity_ok(input logic [PKT_BITS_DEFAULT-1:0] pkt);
        logic w_pld_par;
        w_pld_par = pkt[PLD_BIT] & (^pkt[PLD_MSB:PLD_LSB]);
        return (^pkt[HDR_MSB:HDR_LSB]) ^ (^pkt[KEY_MSB:KEY_LSB]) ^ w_pld_par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cntr.sv
`default_nettype none
// ============================================================================
// Module      : sat_cntr
// Description : Saturating up-counter with synchronous clear. Clear wins
//               over a coincident increment; the count sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cntr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Count increments, holding at the maximum value; clear has priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr_in) begin
            r_count <= '0;
        end else if (inc_in && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/pkt_disassembler.sv
`default_nettype none
// ============================================================================
// Module      : pkt_disassembler
// Description : Receive-side SpiNNaker packet disassembler. Checks parity and
//               type of each accepted packet, forwards multicast key/payload
//               as events through an output register plus one park slot, and
//               counts forwarded, parity-error and non-multicast packets.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_disassembler
    import spif_pkt_pkg::*;
#(
    parameter int PACKET_BITS = spif_pkt_pkg::PKT_BITS_DEFAULT,
    parameter int CNT_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cnt_clr_in,
    input  logic [PACKET_BITS-1:0] pkt_data_in,
    input  logic                   pkt_vld_in,
    output logic                   pkt_rdy_out,
    output logic [31:0]            evt_key_out,
    output logic [31:0]            evt_pld_out,
    output logic                   evt_pld_vld_out,
    output logic                   evt_vld_out,
    input  logic                   evt_rdy_in,
    output logic [CNT_BITS-1:0]    pkt_cnt_out,
    output logic [CNT_BITS-1:0]    par_err_cnt_out,
    output logic [CNT_BITS-1:0]    typ_drp_cnt_out
);

    // Classification of the packet on the input bus
    logic        w_acc;
    logic        w_par_ok;
    logic        w_is_mc;
    logic        w_fwd;
    logic        w_par_err;
    logic        w_typ_drp;
    logic        w_out_busy;
    logic        w_park_now;
    logic [31:0] w_key;
    logic [31:0] w_pld;
    logic        w_pldv;

    // Output register, park slot and ready flag
    logic [31:0] r_evt_key;
    logic [31:0] r_evt_pld;
    logic        r_evt_pldv;
    logic        r_evt_vld;
    logic [31:0] r_park_key;
    logic [31:0] r_park_pld;
    logic        r_park_pldv;
    logic        r_parked;
    logic        r_pkt_rdy;

    assign w_acc      = pkt_vld_in && r_pkt_rdy;
    assign w_par_ok   = pkt_parity_ok(pkt_data_in);
    assign w_is_mc    = (pkt_data_in[TYP_MSB:TYP_LSB] == PKT_TYPE_MC);
    assign w_par_err  = w_acc && !w_par_ok;
    assign w_typ_drp  = w_acc && w_par_ok && !w_is_mc;
    assign w_fwd      = w_acc && w_par_ok && w_is_mc;

    assign w_pldv     = pkt_data_in[PLD_BIT];
    assign w_key      = pkt_data_in[KEY_MSB:KEY_LSB];
    assign w_pld      = w_pldv ? pkt_data_in[PLD_MSB:PLD_LSB] : 32'h0;

    // Output is stalled when an event is being offered and not taken
    assign w_out_busy = r_evt_vld && !evt_rdy_in;
    assign w_park_now = w_fwd && w_out_busy;

    // Event handshake: load output directly when free, otherwise park; drain
    // the park slot as soon as the output frees up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_rdy   <= 1'b0;
            r_evt_vld   <= 1'b0;
            r_evt_key   <= 32'h0;
            r_evt_pld   <= 32'h0;
            r_evt_pldv  <= 1'b0;
            r_park_key  <= 32'h0;
            r_park_pld  <= 32'h0;
            r_park_pldv <= 1'b0;
            r_parked    <= 1'b0;
        end else begin
            // Ready drops only while the park slot is (or is about to be) held
            r_pkt_rdy <= !((r_parked && w_out_busy) || w_park_now);
            r_evt_vld <= w_out_busy || r_parked || w_fwd;

            if (w_out_busy) begin
                if (w_fwd) begin
                    r_park_key  <= w_key;
                    r_park_pld  <= w_pld;
                    r_park_pldv <= w_pldv;
                    r_parked    <= 1'b1;
                end
            end else if (r_parked) begin
                r_evt_key  <= r_park_key;
                r_evt_pld  <= r_park_pld;
                r_evt_pldv <= r_park_pldv;
                r_parked   <= w_fwd;
                if (w_fwd) begin
                    r_park_key  <= w_key;
                    r_park_pld  <= w_pld;
                    r_park_pldv <= w_pldv;
                end
            end else if (w_fwd) begin
                r_evt_key  <= w_key;
                r_evt_pld  <= w_pld;
                r_evt_pldv <= w_pldv;
            end
        end
    end

    assign pkt_rdy_out     = r_pkt_rdy;
    assign evt_vld_out     = r_evt_vld;
    assign evt_key_out     = r_evt_key;
    assign evt_pld_out     = r_evt_pld;
    assign evt_pld_vld_out = r_evt_pldv;

    sat_cntr #(.WIDTH(CNT_BITS)) u_pkt_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_in    (cnt_clr_in),
        .inc_in    (w_fwd),
        .count_out (pkt_cnt_out)
    );

    sat_cntr #(.WIDTH(CNT_BITS)) u_par_err_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_in    (cnt_clr_in),
        .inc_in    (w_par_err),
        .count_out (par_err_cnt_out)
    );

    sat_cntr #(.WIDTH(CNT_BITS)) u_typ_drp_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_in    (cnt_clr_in),
        .inc_in    (w_typ_drp),
        .count_out (typ_drp_cnt_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_pkt_disassembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_disassembler
// Description : Self-checking bench for pkt_disassembler (4-bit counters).
//               Directed scenarios followed by randomized traffic, checked
//               against a queue-based event model with saturating counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_disassembler;

    localparam int CNT_BITS = 4;
    localparam int CNT_MAX  = 15;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cnt_clr_in;
    logic [71:0]         pkt_data_in;
    logic                pkt_vld_in;
    logic                pkt_rdy_out;
    logic [31:0]         evt_key_out;
    logic [31:0]         evt_pld_out;
    logic                evt_pld_vld_out;
    logic                evt_vld_out;
    logic                evt_rdy_in;
    logic [CNT_BITS-1:0] pkt_cnt_out;
    logic [CNT_BITS-1:0] par_err_cnt_out;
    logic [CNT_BITS-1:0] typ_drp_cnt_out;

    always #5 clk = ~clk;

    pkt_disassembler #(.PACKET_BITS(72), .CNT_BITS(CNT_BITS)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cnt_clr_in      (cnt_clr_in),
        .pkt_data_in     (pkt_data_in),
        .pkt_vld_in      (pkt_vld_in),
        .pkt_rdy_out     (pkt_rdy_out),
        .evt_key_out     (evt_key_out),
        .evt_pld_out     (evt_pld_out),
        .evt_pld_vld_out (evt_pld_vld_out),
        .evt_vld_out     (evt_vld_out),
        .evt_rdy_in      (evt_rdy_in),
        .pkt_cnt_out     (pkt_cnt_out),
        .par_err_cnt_out (par_err_cnt_out),
        .typ_drp_cnt_out (typ_drp_cnt_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] key;
        logic [31:0] pld;
        logic        pv;
    } evt_t;

    evt_t m_q[$];
    int   m_pkt;
    int   m_par;
    int   m_typ;

    // Packet is good when the count of ones over the covered fields is odd
    function automatic bit ref_par_ok(input logic [71:0] p);
        int ones;
        ones = $countones(p[7:0]) + $countones(p[39:8]);
        if (p[1]) ones += $countones(p[71:40]);
        return (ones % 2) == 1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    function automatic logic [71:0] mk(input logic [31:0] pld, input logic [31:0] key,
                                       input logic [7:0] hdr);
        return {pld, key, hdr};
    endfunction

    // Build a packet and flip the parity bit if needed so it passes
    function automatic logic [71:0] mk_good(input logic [31:0] pld, input logic [31:0] key,
                                            input logic [7:0] hdr);
        logic [71:0] p;
        p = {pld, key, hdr};
        if (!ref_par_ok(p)) p[0] = ~p[0];
        return p;
    endfunction

    function automatic logic [71:0] rnd_pkt();
        logic [7:0]  h;
        logic [31:0] k;
        logic [31:0] p;
        logic [71:0] r;
        h = 8'($urandom);
        k = $urandom;
        p = $urandom;
        if ($urandom_range(0, 9) < 8) h[7:6] = 2'b00;
        r = {p, k, h};
        if ($urandom_range(0, 9) < 8 && !ref_par_ok(r)) r[0] = ~r[0];
        return r;
    endfunction

    // One clock: check state after the previous edge, drive inputs, then
    // advance the model for the handshakes that the next edge completes
    task automatic step(input logic vld, input logic [71:0] data,
                        input logic erdy, input logic clr);
        int   occ;
        evt_t e;
        @(negedge clk);
        check("evt_vld", 32'(evt_vld_out), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("evt_key", evt_key_out, m_q[0].key);
            check("evt_pld", evt_pld_out, m_q[0].pld);
            check("evt_pld_vld", 32'(evt_pld_vld_out), 32'(m_q[0].pv));
        end
        check("pkt_rdy", 32'(pkt_rdy_out), 32'(m_q.size() < 2));
        check("pkt_cnt", 32'(pkt_cnt_out), m_pkt);
        check("par_err_cnt", 32'(par_err_cnt_out), m_par);
        check("typ_drp_cnt", 32'(typ_drp_cnt_out), m_typ);

        pkt_vld_in  = vld;
        pkt_data_in = data;
        evt_rdy_in  = erdy;
        cnt_clr_in  = clr;

        occ = m_q.size();
        if (evt_vld_out && erdy && m_q.size() != 0) void'(m_q.pop_front());
        if (vld && pkt_rdy_out) begin
            if (!ref_par_ok(data)) begin
                m_par = sat_inc(m_par);
            end else if (data[7:6] != 2'b00) begin
                m_typ = sat_inc(m_typ);
            end else begin
                check("fwd_while_full", 32'(occ >= 2), 32'h0);
                e.key = data[39:8];
                e.pld = data[1] ? data[71:40] : 32'h0;
                e.pv  = data[1];
                m_q.push_back(e);
                m_pkt = sat_inc(m_pkt);
            end
        end
        if (clr) begin
            m_pkt = 0;
            m_par = 0;
            m_typ = 0;
        end
    endtask

    task automatic idle(input logic erdy);
        step(1'b0, 72'h0, erdy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"}, 32'(pkt_rdy_out), 32'h0);
        check({tag, "_vld"}, 32'(evt_vld_out), 32'h0);
        check({tag, "_key"}, evt_key_out, 32'h0);
        check({tag, "_pld"}, evt_pld_out, 32'h0);
        check({tag, "_pv"}, 32'(evt_pld_vld_out), 32'h0);
        check({tag, "_pcnt"}, 32'(pkt_cnt_out), 32'h0);
        check({tag, "_pecnt"}, 32'(par_err_cnt_out), 32'h0);
        check({tag, "_tcnt"}, 32'(typ_drp_cnt_out), 32'h0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pkt = 0;
        m_par = 0;
        m_typ = 0;
    endtask

    initial begin
        model_reset();
        reset_n     = 1'b0;
        cnt_clr_in  = 1'b0;
        pkt_data_in = 72'h0;
        pkt_vld_in  = 1'b0;
        evt_rdy_in  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        #1 check("rdy_before_first_edge", 32'(pkt_rdy_out), 32'h0);

        // Plain multicast packet, key 1, no payload
        step(1'b1, mk(32'h0, 32'h1, 8'h00), 1'b1, 1'b0);
        step(1'b0, 72'h0, 1'b1, 1'b0);
        check("tp1_key", evt_key_out, 32'h1);
        check("tp1_pv", 32'(evt_pld_vld_out), 32'h0);
        check("tp1_cnt", 32'(pkt_cnt_out), 32'h1);

        // Bad parity dropped, then the corrected packet forwarded
        step(1'b1, mk(32'h0, 32'h3, 8'h00), 1'b1, 1'b0);
        step(1'b1, mk(32'h0, 32'h3, 8'h01), 1'b1, 1'b0);
        check("tp2_par_cnt", 32'(par_err_cnt_out), 32'h1);
        check("tp2_rdy", 32'(pkt_rdy_out), 32'h1);

        // Payload present, then a P2P packet dropped
        step(1'b1, mk(32'h1, 32'h1, 8'h02), 1'b1, 1'b0);
        step(1'b1, mk(32'h0, 32'h1, 8'h41), 1'b1, 1'b0);
        check("tp3_pld", evt_pld_out, 32'h1);
        check("tp3_pv", 32'(evt_pld_vld_out), 32'h1);
        idle(1'b1);
        check("tp3_typ_cnt", 32'(typ_drp_cnt_out), 32'h1);
        idle(1'b1);

        // Back-pressure: first held, second parked, then both drained in order
        step(1'b1, mk(32'h0, 32'h10, 8'h00), 1'b0, 1'b0);
        step(1'b1, mk(32'h0, 32'h11, 8'h01), 1'b0, 1'b0);
        idle(1'b0);
        check("tp4_rdy_low", 32'(pkt_rdy_out), 32'h0);
        check("tp4_hold_key", evt_key_out, 32'h10);
        idle(1'b1);
        idle(1'b1);
        check("tp4_second_key", evt_key_out, 32'h11);
        idle(1'b1);
        check("tp4_rdy_back", 32'(pkt_rdy_out), 32'h1);
        check("tp4_drained", 32'(evt_vld_out), 32'h0);

        // Saturation of the forwarded-packet counter, then clear with a packet
        for (int i = 0; i < 14; i++) begin
            step(1'b1, mk_good(32'h0, 32'h100 + 32'(i), 8'h00), 1'b1, 1'b0);
        end
        idle(1'b1);
        check("sat_pkt_cnt", 32'(pkt_cnt_out), 32'd15);
        step(1'b1, mk_good(32'h0, 32'h200, 8'h00), 1'b1, 1'b1);
        step(1'b0, 72'h0, 1'b1, 1'b0);
        check("clr_pkt_cnt", 32'(pkt_cnt_out), 32'h0);
        check("clr_par_cnt", 32'(par_err_cnt_out), 32'h0);

        // Randomized traffic with random back-pressure and occasional clears
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 9) < 7), rnd_pkt(),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 199) == 0));
        end

        // Reset with output valid and the park slot full
        idle(1'b1);
        idle(1'b1);
        step(1'b1, mk_good(32'h0, 32'h20, 8'h00), 1'b0, 1'b0);
        step(1'b1, mk_good(32'h0, 32'h21, 8'h00), 1'b0, 1'b0);
        idle(1'b0);
        check("pre_rst_rdy", 32'(pkt_rdy_out), 32'h0);
        #2 reset_n = 1'b0;
        #1 check_reset_state("midrst");
        model_reset();
        pkt_vld_in = 1'b0;
        cnt_clr_in = 1'b0;
        evt_rdy_in = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, mk(32'h0, 32'h7, 8'h00), 1'b1, 1'b0);
        step(1'b0, 72'h0, 1'b1, 1'b0);
        check("post_rst_key", evt_key_out, 32'h7);
        check("post_rst_cnt", 32'(pkt_cnt_out), 32'h1);
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #500000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
